// File: rtl/genesis_pad_scheduler_if.sv
// Pad-side and capture-side signals of the Genesis pad scheduler.
// The master modport belongs to whoever drives the pads and the poll request; the slave modport belongs to the scheduler.
interface genesis_pad_scheduler_if;
    logic        iPOLL_REQ;
    logic [5:0]  iPAD1;
    logic [5:0]  iPAD2;
    logic        oSELECT1;
    logic        oSELECT2;
    logic        oCAP_VALID;
    logic        oCAP_PORT;
    logic [47:0] oCAP_DATA;
    logic        oBUSY;

    modport master (
        output iPOLL_REQ,
        output iPAD1,
        output iPAD2,
        input  oSELECT1,
        input  oSELECT2,
        input  oCAP_VALID,
        input  oCAP_PORT,
        input  oCAP_DATA,
        input  oBUSY
    );

    modport slave (
        input  iPOLL_REQ,
        input  iPAD1,
        input  iPAD2,
        output oSELECT1,
        output oSELECT2,
        output oCAP_VALID,
        output oCAP_PORT,
        output oCAP_DATA,
        output oBUSY
    );
endinterface

// File: rtl/genesis_pad_scheduler.sv
// Polls two Genesis pads in turn. Each poll is eight SELECT half-phases, and one 6-bit sample is taken per half-phase.
// The eight samples are published as a 48-bit capture, followed by a cooldown before the next poll request is served.
//
// state      | meaning
// S_IDLE     | waiting for a pending poll request
// S_POLL1    | toggling SELECT1, sampling port 1 once per half-phase
// S_POLL2    | toggling SELECT2, sampling port 2 once per half-phase
// S_COOLDOWN | fixed holdoff after a round; requests are only latched
module genesis_pad_scheduler #(
    parameter int unsigned HALF_CYC = 400,
    parameter int unsigned IDLE_CYC = 100000
) (
    input  logic                    iCLK,
    input  logic                    iN_RESET,
    genesis_pad_scheduler_if.slave  pad_bus
);

    localparam int HW = $clog2(HALF_CYC);
    localparam int IW = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;
    localparam logic [HW-1:0] HALF_LOAD = HW'(HALF_CYC - 1);
    localparam logic [IW-1:0] IDLE_LOAD = IW'(IDLE_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_POLL1,
        S_POLL2,
        S_COOLDOWN
    } state_t;

    state_t        state_q, state_d;
    logic          pending_q, pending_d;
    logic [2:0]    phase_q, phase_d;
    logic [HW-1:0] half_cnt_q, half_cnt_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic [47:0]   shadow_q, shadow_d;
    logic [47:0]   cap_data_q, cap_data_d;
    logic          cap_port_q, cap_port_d;
    logic          cap_valid_q, cap_valid_d;
    logic          sel1_q, sel1_d;
    logic          sel2_q, sel2_d;

    logic [5:0]    pad1_meta_q, pad1_sync_q;
    logic [5:0]    pad2_meta_q, pad2_sync_q;
    logic [5:0]    sample;

    // Idle pads read all-ones, so the synchronisers come out of reset in that state.
    always_ff @(posedge iCLK or negedge iN_RESET) begin
        if (!iN_RESET) begin
            pad1_meta_q <= 6'h3F;
            pad1_sync_q <= 6'h3F;
            pad2_meta_q <= 6'h3F;
            pad2_sync_q <= 6'h3F;
        end else begin
            pad1_meta_q <= pad_bus.iPAD1;
            pad1_sync_q <= pad1_meta_q;
            pad2_meta_q <= pad_bus.iPAD2;
            pad2_sync_q <= pad2_meta_q;
        end
    end

    always_ff @(posedge iCLK or negedge iN_RESET) begin
        if (!iN_RESET) begin
            state_q     <= S_IDLE;
            pending_q   <= 1'b0;
            phase_q     <= 3'd0;
            half_cnt_q  <= '0;
            idle_cnt_q  <= '0;
            shadow_q    <= '0;
            cap_data_q  <= '0;
            cap_port_q  <= 1'b0;
            cap_valid_q <= 1'b0;
            sel1_q      <= 1'b1;
            sel2_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            phase_q     <= phase_d;
            half_cnt_q  <= half_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            shadow_q    <= shadow_d;
            cap_data_q  <= cap_data_d;
            cap_port_q  <= cap_port_d;
            cap_valid_q <= cap_valid_d;
            sel1_q      <= sel1_d;
            sel2_q      <= sel2_d;
        end
    end

    assign sample = (state_q == S_POLL2) ? pad2_sync_q : pad1_sync_q;

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q | pad_bus.iPOLL_REQ;
        phase_d     = phase_q;
        half_cnt_d  = half_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        shadow_d    = shadow_q;
        cap_data_d  = cap_data_q;
        cap_port_d  = cap_port_q;
        cap_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pending_q) begin
                    state_d    = S_POLL1;
                    pending_d  = pad_bus.iPOLL_REQ;
                    phase_d    = 3'd0;
                    half_cnt_d = HALF_LOAD;
                end
            end

            S_POLL1, S_POLL2: begin
                if (half_cnt_q == '0) begin
                    shadow_d[6*phase_q +: 6] = sample;
                    half_cnt_d               = HALF_LOAD;
                    if (phase_q == 3'd7) begin
                        // Slot 7 bypasses the shadow so it lands in the same edge as the pulse.
                        cap_valid_d = 1'b1;
                        cap_data_d  = {sample, shadow_q[41:0]};
                        cap_port_d  = (state_q == S_POLL2);
                        phase_d     = 3'd0;
                        if (state_q == S_POLL1) begin
                            state_d = S_POLL2;
                        end else begin
                            state_d    = S_COOLDOWN;
                            idle_cnt_d = IDLE_LOAD;
                        end
                    end else begin
                        phase_d = phase_q + 3'd1;
                    end
                end else begin
                    half_cnt_d = half_cnt_q - HW'(1);
                end
            end

            S_COOLDOWN: begin
                if (idle_cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q - IW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // SELECT lines are registered from the next state so the pad sees no decode glitches.
        sel1_d = !((state_d == S_POLL1) && !phase_d[0]);
        sel2_d = !((state_d == S_POLL2) && !phase_d[0]);
    end

    assign pad_bus.oSELECT1   = sel1_q;
    assign pad_bus.oSELECT2   = sel2_q;
    assign pad_bus.oCAP_VALID = cap_valid_q;
    assign pad_bus.oCAP_PORT  = cap_port_q;
    assign pad_bus.oCAP_DATA  = cap_data_q;
    assign pad_bus.oBUSY      = (state_q != S_IDLE);

endmodule

// File: doc/genesis_pad_scheduler.md
GENESIS_PAD_SCHEDULER -- requirements
Module: genesis_pad_scheduler

Interface
REQ-001 SHALL have parameter HALF_CYC, default 400, clocks per SELECT half-phase, legal range 2..65535.
REQ-002 SHALL have parameter IDLE_CYC, default 100000, cooldown clocks after a poll round, legal range 1..2^20-1.
REQ-003 SHALL have port iCLK, input, 1, the single system clock; all state on its rising edge.
REQ-004 SHALL have port iN_RESET, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port iPOLL_REQ, input, 1, poll request (e.g. vblank), synchronous to iCLK.
REQ-006 SHALL have port iPAD1, input, 6, port 1 pins {C/Start,B/A,Up/Z,Down/Y,Left/X,Right/Mode}, asynchronous, active-low.
REQ-007 SHALL have port iPAD2, input, 6, port 2 pins, same encoding as iPAD1.
REQ-008 SHALL have port oSELECT1, output, 1, port 1 SELECT line.
REQ-009 SHALL have port oSELECT2, output, 1, port 2 SELECT line.
REQ-010 SHALL have port oCAP_VALID, output, 1, one-clock pulse marking a complete capture.
REQ-011 SHALL have port oCAP_PORT, output, 1, port of the last capture (0 = port 1, 1 = port 2).
REQ-012 SHALL have port oCAP_DATA, output, 48, eight raw 6-bit samples; slot k at bits [6k+5:6k].
REQ-013 SHALL have port oBUSY, output, 1, high while polling or cooling down.

Function
REQ-014 iPAD1/iPAD2 SHALL pass through 2-flop synchronisers; all sampling uses synchronised values.
REQ-015 States SHALL be IDLE, POLL1, POLL2, COOLDOWN.
REQ-016 Any clock with iPOLL_REQ=1 SHALL set a single pending flag; further requests while pending set collapse into it.
REQ-017 In IDLE with pending set, the FSM SHALL enter POLL1 on the next edge and clear pending on the same edge.
REQ-018 A request in the same clock COOLDOWN exits SHALL be honoured: set pending, then POLL1 one clock later.
REQ-019 POLLn SHALL run phases k=0..7, each exactly HALF_CYC clocks.
REQ-020 During POLLn phase k, the selected SELECT SHALL be low for even k, high for odd k.
REQ-021 The non-polled SELECT, and both SELECTs outside POLL states, SHALL be high.
REQ-022 On the last clock of phase k, the synchronised port-n value SHALL be written into oCAP_DATA slot k.
REQ-023 Slot writes SHALL go to a shadow buffer; oCAP_DATA and oCAP_PORT SHALL update only together with the oCAP_VALID pulse.
REQ-024 oCAP_VALID SHALL pulse for exactly one clock, the clock after phase 7's sample.
REQ-025 oCAP_DATA and oCAP_PORT SHALL hold until the next pulse.
REQ-026 POLL1 SHALL go directly to POLL2 phase 0 on the same edge that raises oCAP_VALID for port 1.
REQ-027 POLL2 SHALL go to COOLDOWN on the same edge that raises oCAP_VALID for port 2.
REQ-028 COOLDOWN SHALL last exactly IDLE_CYC clocks and then go to IDLE; requests are only latched there, never served.
REQ-029 oBUSY SHALL be high exactly while the state is POLL1, POLL2 or COOLDOWN.
REQ-030 Phase and cooldown counters SHALL be sized to hold HALF_CYC-1 and IDLE_CYC-1, count down, and reload on phase and state change.

Reset
REQ-031 While iN_RESET=0, outputs SHALL be: oSELECT1=1, oSELECT2=1, oCAP_VALID=0, oCAP_PORT=0, oCAP_DATA=0, oBUSY=0.
REQ-032 While iN_RESET=0: state IDLE, pending cleared, counters and shadow buffer zero, synchronisers all-ones.
REQ-033 Reset asserted mid-poll SHALL abort with no oCAP_VALID pulse; the first poll after release needs a fresh iPOLL_REQ.

Verification (HALF_CYC=4, IDLE_CYC=16)
REQ-034 Bench SHALL cover idle pads: pads idle 6'h3F, iPOLL_REQ pulse -> SELECT1 low 2 clocks after the pulse; pattern L/H x4 at 4 clocks each; VALID with PORT=0, DATA=48'hFFFF_FFFF_FFFF; VALID with PORT=1 32 clocks later.
REQ-035 Bench SHALL cover per-slot capture: iPAD1 driven per phase to k+1 (k=0..7), changed >=3 clocks before each phase end -> DATA slot k = k+1.
REQ-036 Bench SHALL cover request collapse: 3 requests during POLL2 -> exactly one extra round, starting 1 clock after COOLDOWN ends; BUSY low for exactly 1 clock in between.
REQ-037 Bench SHALL cover mid-poll reset: iN_RESET low at POLL1 phase 5 -> both SELECT high and DATA=0 asynchronously; no VALID after release without a new request.
REQ-038 Bench SHALL cover port isolation: iPAD2 toggled throughout POLL1 -> port-1 capture unaffected; SELECT2 stays high throughout POLL1.
